// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: address width, default reset
// vector and the fetch-unit state encoding.
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its pc while the
// downstream stage is stalled.
module fetch_skid_buf #(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              full,
  output logic [31:0]       data,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
      pc   <= '0;
    end else begin
      if (clear || unload)
        full <= 1'b0;
      else if (load)
        full <= 1'b1;
      if (load) begin
        data <= in_data;
        pc   <= in_pc;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one fetch per cycle, skid entry for downstream
// stalls, and redirect handling that waits out a stale open request.
module fetch_unit #(
  parameter int                ADDR_W       = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = mips_pkg::DEFAULT_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  import mips_pkg::*;

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, stale_addr, stale_n, target;
  logic              xfer, load_mem, load_skid, retire;
  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [31:0]       skid_data;
  logic [ADDR_W-1:0] skid_pc;

  // In DROP the stale address stays on the bus while pc already holds the target.
  assign target    = jump_target & ~ADDR_W'(3);
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = (state == DROP) ? stale_addr : pc;
  assign xfer      = imem_req && imem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      stale_addr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      stale_addr <= stale_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    stale_n     = stale_addr;
    load_mem    = 1'b0;
    load_skid   = 1'b0;
    retire      = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    if (jump) begin
      // Jump beats stall; an unacked open request must finish before redirecting.
      pc_n       = target;
      skid_clear = 1'b1;
      retire     = 1'b1;
      if (state != HOLD && !imem_ack) begin
        state_n = DROP;
        if (state == FETCH)
          stale_n = pc;
      end else begin
        state_n = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (xfer) begin
            pc_n = pc + ADDR_W'(4);
            if (!if_valid || !stall) begin
              load_mem = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_n   = HOLD;
            end
          end else if (if_valid && !stall) begin
            retire = 1'b1;
          end
        end
        HOLD: begin
          if (!stall && skid_full) begin
            load_skid   = 1'b1;
            skid_unload = 1'b1;
            state_n     = FETCH;
          end
        end
        DROP: begin
          if (imem_ack)
            state_n = FETCH;
          if (if_valid && !stall)
            retire = 1'b1;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else if (load_mem) begin
      if_valid    <= 1'b1;
      if_instr    <= imem_rdata;
      if_pc       <= imem_addr;
      if_pc_plus4 <= imem_addr + ADDR_W'(4);
    end else if (load_skid) begin
      if_valid    <= 1'b1;
      if_instr    <= skid_data;
      if_pc       <= skid_pc;
      if_pc_plus4 <= skid_pc + ADDR_W'(4);
    end else if (retire) begin
      if_valid    <= 1'b0;
    end
  end

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .in_data (imem_rdata),
    .in_pc   (imem_addr),
    .full    (skid_full),
    .data    (skid_data),
    .pc      (skid_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenario tasks plus a negedge scoreboard
// that predicts fetch addresses and delivered words from its own pc model.
module tb_fetch_unit;

  logic        clk, rst, jump, stall, imem_req, imem_ack, if_valid;
  logic [31:0] jump_target, imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] mpc    = 32'h0;
  logic [31:0] mstale = 32'h0;
  logic        mdrop  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_F00F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .jump        (jump),
    .jump_target (jump_target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard: reference pc/redirect model, word order and payload check.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mpc   = 32'h0;
      mdrop = 1'b0;
    end else begin
      if (imem_req) begin
        checks++;
        if (imem_addr !== (mdrop ? mstale : mpc)) begin
          failures++;
          $display("[TB] FAIL sb_addr: imem_addr=%h expected %h", imem_addr, mdrop ? mstale : mpc);
        end
      end
      if (if_valid && !stall) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_extra: unexpected word pc=%h instr=%h, expected none", if_pc, if_instr);
        end else begin
          e = sb.pop_front();
          if (if_instr !== e.instr || if_pc !== e.pc || if_pc_plus4 !== e.pc + 32'd4) begin
            failures++;
            $display("[TB] FAIL sb_word: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                     if_pc, if_instr, if_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (jump) begin
        sb.delete();
        if (imem_req && !imem_ack) begin
          if (!mdrop) mstale = mpc;
          mdrop = 1'b1;
        end else begin
          mdrop = 1'b0;
        end
        mpc = {jump_target[31:2], 2'b00};
      end else if (imem_req && imem_ack) begin
        if (mdrop) begin
          mdrop = 1'b0;
        end else begin
          sb.push_back({mem_word(mpc), mpc});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; jump = 1'b0; jump_target = 32'h0; stall = 1'b0; imem_ack = 1'b0;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: req=%b valid=%b expected 0 0", imem_req, if_valid);
    end
    checks++;
    if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: instr=%h pc=%h pc4=%h expected zeros", if_instr, if_pc, if_pc_plus4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_release: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (imem_addr !== 32'(4 * k) || if_valid !== (k > 0)) begin
        failures++;
        $display("[TB] FAIL b2b_addr[%0d]: addr=%h valid=%b expected %h %b", k, imem_addr, if_valid, 32'(4 * k), k > 0);
      end
      if (k > 0) begin
        checks++;
        if (if_pc !== 32'(4 * (k - 1))) begin
          failures++;
          $display("[TB] FAIL b2b_pc[%0d]: if_pc=%h expected %h", k, if_pc, 32'(4 * (k - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 4; k++) begin
      imem_ack = (k == 3);
      #1;
      checks++;
      if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wait_addr[%0d]: addr=%h req=%b expected 00000010 1", k, imem_addr, imem_req);
      end
      if (k > 0) begin
        checks++;
        if (if_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL wait_idle[%0d]: if_valid=%b expected 0", k, if_valid);
        end
      end
      tick();
    end
    imem_ack = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10) begin
      failures++;
      $display("[TB] FAIL wait_pulse: valid=%b pc=%h expected 1 00000010", if_valid, if_pc);
    end
    tick();
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wait_retire: if_valid=%b expected 0", if_valid);
    end
  endtask

  task automatic test_jump_drop();
    jump = 1'b1; jump_target = 32'h200; imem_ack = 1'b0;
    tick();
    jump = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h14 || imem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_hold: addr=%h req=%b expected 00000014 1", imem_addr, imem_req);
    end
    tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h200 || if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_redirect: addr=%h valid=%b expected 00000200 0", imem_addr, if_valid);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h300;
    tick();
    jump_target = 32'h400;
    tick();
    jump = 1'b0; imem_ack = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h204) begin
      failures++;
      $display("[TB] FAIL drop_stale2: addr=%h expected 00000204", imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h400) begin
      failures++;
      $display("[TB] FAIL drop_last_wins: addr=%h expected 00000400", imem_addr);
    end
  endtask

  task automatic test_stall_skid();
    jump = 1'b1; jump_target = 32'h1000; imem_ack = 1'b1; stall = 1'b0;
    tick();
    jump = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h1000) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: req=%b valid=%b pc=%h expected 0 1 00001000", k, imem_req, if_valid, if_pc);
      end
      if (k == 0) tick();
    end
    stall = 1'b0;
    tick();
    checks++;
    if (if_pc !== 32'h1004 || imem_req !== 1'b1 || imem_addr !== 32'h1008) begin
      failures++;
      $display("[TB] FAIL stall_release: pc=%h req=%b addr=%h expected 00001004 1 00001008", if_pc, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (if_pc !== 32'h1008 || if_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_next: pc=%h valid=%b expected 00001008 1", if_pc, if_valid);
    end
  endtask

  task automatic test_jump_over_stall();
    jump = 1'b1; jump_target = 32'h203; stall = 1'b1; imem_ack = 1'b1;
    tick();
    jump = 1'b0; stall = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL jstall: valid=%b addr=%h req=%b expected 0 00000200 1", if_valid, imem_addr, imem_req);
    end
    tick();
    checks++;
    if (if_pc !== 32'h200 || if_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL jstall_fetch: pc=%h valid=%b expected 00000200 1", if_pc, if_valid);
    end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC; imem_ack = 1'b1;
    tick();
    jump = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wrap: addr=%h pc=%h pc4=%h expected 00000000 fffffffc 00000000", imem_addr, if_pc, if_pc_plus4);
    end
  endtask

  task automatic test_reset_mid();
    imem_ack = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_async: req=%b valid=%b expected 0 0", imem_req, if_valid);
    end
    tick();
    rst = 1'b0; imem_ack = 1'b1;
    tick();
    checks++;
    if (if_pc !== 32'h0 || if_valid !== 1'b1 || imem_addr !== 32'h4) begin
      failures++;
      $display("[TB] FAIL rstmid_restart: pc=%h valid=%b addr=%h expected 00000000 1 00000004", if_pc, if_valid, imem_addr);
    end
  endtask

  task automatic test_drain();
    imem_ack = 1'b0; stall = 1'b0; jump = 1'b0;
    for (int k = 0; k < 8 && (sb.size() != 0 || if_valid); k++)
      tick();
    tick();
    checks++;
    if (sb.size() != 0 || if_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drain: pending=%0d valid=%b expected 0 0", sb.size(), if_valid);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_jump_drop();
    test_stall_skid();
    test_jump_over_stall();
    test_wrap();
    test_reset_mid();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter ADDR_W, 32, the PC and address width.
REQ-003 The interface SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 jump  in  1  taken-branch indication from the branch decision stage, already qualified by valid.
REQ-007 jump_target  in  ADDR_W  redirect address; bits [1:0] ignored and treated as 0.
REQ-008 stall  in  1  downstream cannot accept the current if_* word this cycle.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  ADDR_W  word-aligned fetch address.
REQ-011 imem_ack  in  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 if_valid  out  1  if_instr/if_pc/if_pc_plus4 hold a live instruction.
REQ-014 if_instr  out  32  fetched instruction.
REQ-015 if_pc  out  ADDR_W  address of if_instr.
REQ-016 if_pc_plus4  out  ADDR_W  if_pc+4, modulo 2^ADDR_W.

Function
REQ-017 States SHALL be FETCH (request outstanding or about to issue), HOLD (skid entry full, no request) and DROP (redirect pending, stale request outstanding).
REQ-018 Handshake: while imem_req=1 and imem_ack=0, imem_addr SHALL stay stable, including through a jump or stall.
REQ-019 Transfer: a transfer completes on a clock edge where imem_req=1 and imem_ack=1.
REQ-020 Back-to-back: in FETCH, imem_req SHALL be 1 whenever the output slot or skid entry can take the result, giving one fetch per cycle at full throughput.
REQ-021 PC advance: on each accepted transfer not discarded, pc SHALL become pc+4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-022 Output update: if_valid=0 or stall=0 at an accepted transfer SHALL load if_* from imem_rdata/imem_addr on the next edge, with if_valid=1.
REQ-023 Skid capture: if_valid=1 and stall=1 at an accepted transfer SHALL capture the word into the one-entry skid and enter HOLD.
REQ-024 In HOLD: imem_req=0, and when stall drops the skid word moves to if_* and the unit returns to FETCH.
REQ-025 Output retire: if_valid=1, stall=0 and no new word available SHALL clear if_valid on the next edge.
REQ-026 jump=1 SHALL have the following effect on the next edge: if_valid=0, skid cleared, pc=jump_target.
REQ-027 Flush: jump=1 SHALL discard any transfer completing in the same cycle.
REQ-028 Jump with no stale request: jump=1 with no request outstanding, or with imem_ack=1 that cycle, SHALL present imem_addr=jump_target with imem_req=1 on the next cycle.
REQ-029 Jump into DROP: jump=1 with a request outstanding and imem_ack=0 SHALL enter DROP, keeping the stale address until ack, discarding that data, then fetching jump_target.
REQ-030 Jump during DROP: a second jump during DROP SHALL overwrite the pending target; the last target wins.
REQ-031 Priority: jump SHALL override stall in the same cycle.
REQ-032 Jump and stall never change an imem_addr whose handshake is still open.

Reset
REQ-033 While rst=1 the unit SHALL drive: pc=RESET_VECTOR, state FETCH, imem_req=0, if_valid=0, skid empty, if_instr/if_pc/if_pc_plus4=0.
REQ-034 After release: the first cycle after rst deasserts SHALL drive imem_req=1, imem_addr=RESET_VECTOR.
REQ-035 Reset mid-handshake SHALL abandon the outstanding request with no recovery of its data.

Structure
REQ-036 Shared package mips_pkg SHALL hold ADDR_W, RESET_VECTOR default and the fetch state enum (FETCH, HOLD, DROP).
REQ-037 The one-entry skid SHALL be a sub-module fetch_skid_buf (data+pc, full flag, load/unload).

Verification
REQ-038 Reset release, ack every cycle, stall=0 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc follows one cycle later; if_valid=1 from cycle 2.
REQ-039 imem_ack held low 3 cycles at addr 0x10 -> imem_addr stays 0x10 for 4 cycles; one if_valid pulse with if_pc=0x10.
REQ-040 stall=1 for 2 cycles while ack=1 -> if_* frozen, skid captures next word, imem_req=0; after release words arrive in order with no loss or duplication.
REQ-041 jump=1, target=0x200 while 0x14 is outstanding with ack=0 -> imem_addr stays 0x14 until ack, 0x14 data never reaches if_*, next imem_addr=0x200.
REQ-042 jump=1, target=0x203, with stall=1 and ack=1 the same cycle -> if_valid=0 next cycle, acked data dropped, imem_addr=0x200.
REQ-043 pc=0xFFFF_FFFC with ack=1 -> next imem_addr=0x0000_0000, if_pc_plus4=0x0000_0000.
